sc_core_oz_rf_mp: RTL and testbench

Parametrised multi-read-port integer register file with an integrated pending-write scoreboard.
- Successor to the fixed 31x32 register file of the single-cycle core.
- Generalised in data width, register count and read-port count; optional write-to-read bypass; optional hardwired-zero register 0.
- Tracks registers awaiting writeback so the core's issue logic can stall on read-after-write hazards.

---
 rtl/sc_core_oz_pkg.sv | 20 ++
 rtl/sc_core_oz_rf_sb.sv | 79 +++++++
 rtl/sc_core_oz_rf_mp.sv | 104 ++++++++++
 tb/tb_sc_core_oz_rf_mp.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_core_oz_pkg.sv
// ---------------------------------------------------------------------------
// sc_core_oz_pkg
// Shared definitions for the sc_core_oz register file slice: default
// geometry of the integer register file, the architectural address/data
// types, and the index of the hardwired-zero register.
// Ports: none (package).
// ---------------------------------------------------------------------------
package sc_core_oz_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_NUM_RD   = 2;

    typedef logic [4:0]  t_rf_addr;
    typedef logic [31:0] t_rf_data;

    // Register 0 is the hardwired-zero register when ZERO_REG is enabled.
    localparam int X0_ADDR = 0;

endpackage : sc_core_oz_pkg

// File: rtl/sc_core_oz_rf_sb.sv
// ---------------------------------------------------------------------------
// sc_core_oz_rf_sb
// Pending-write scoreboard for the register file: one pending bit per
// register plus a registered population count of those bits.
// Ports:
//   clk            core clock, rising edge
//   rst            synchronous active-high reset, clears all bits and count
//   i_set_en       issue marks i_set_addr as awaiting writeback
//   i_set_addr     destination to mark (validated here)
//   i_clr_en       accepted writeback (already validated by the top)
//   i_clr_addr     writeback destination whose bit is cleared
//   o_pending      pending bit vector, one bit per register
//   o_pending_cnt  number of pending registers
// ---------------------------------------------------------------------------
module sc_core_oz_rf_sb
    import sc_core_oz_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_set_en,
    input  logic [ADDR_W-1:0]   i_set_addr,
    input  logic                i_clr_en,
    input  logic [ADDR_W-1:0]   i_clr_addr,
    output logic [NUM_REGS-1:0] o_pending,
    output logic [CNT_W-1:0]    o_pending_cnt
);

    localparam logic [ADDR_W:0]   LP_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LP_X0       = ADDR_W'(X0_ADDR);

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_cnt;

    logic w_set_vld;
    logic w_same;
    logic w_inc;
    logic w_dec;

    // Out-of-range destinations and the zero register never become pending.
    assign w_set_vld = i_set_en && ({1'b0, i_set_addr} < LP_NUM_REGS)
                       && !((ZERO_REG != 0) && (i_set_addr == LP_X0));

    // A set and a clear on the same register leave it pending, so that
    // clear must not be counted as a decrement.
    assign w_same = w_set_vld && i_clr_en && (i_set_addr == i_clr_addr);
    assign w_inc  = w_set_vld && !r_pending[i_set_addr];
    assign w_dec  = i_clr_en && r_pending[i_clr_addr] && !w_same;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            if (i_clr_en) begin
                r_pending[i_clr_addr] <= 1'b0;
            end
            // Last assignment wins: a same-cycle set overrides the clear.
            if (w_set_vld) begin
                r_pending[i_set_addr] <= 1'b1;
            end
            if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_pending     = r_pending;
    assign o_pending_cnt = r_cnt;

endmodule : sc_core_oz_rf_sb

// File: rtl/sc_core_oz_rf_mp.sv
// ---------------------------------------------------------------------------
// sc_core_oz_rf_mp
// Parametrised multi-read-port integer register file with an integrated
// pending-write scoreboard used by issue logic for RAW hazard stalls.
// Ports:
//   clk          core clock, rising edge
//   rst          synchronous active-high reset, clears data and scoreboard
//   wr_en        writeback enable
//   wr_addr      writeback destination
//   wr_data      writeback data
//   rd_addr      read addresses, one per port
//   rd_data      combinational read data, one per port
//   rd_busy      addressed register has an outstanding write, per port
//   sb_set_en    issue marks sb_set_addr as pending
//   sb_set_addr  destination to mark
//   pending_cnt  number of pending registers
// ---------------------------------------------------------------------------
module sc_core_oz_rf_mp
    import sc_core_oz_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]                rd_busy,
    input  logic                             sb_set_en,
    input  logic [ADDR_W-1:0]                sb_set_addr,
    output logic [$clog2(NUM_REGS+1)-1:0]    pending_cnt
);

    localparam int                CNT_W       = $clog2(NUM_REGS + 1);
    localparam logic [ADDR_W:0]   LP_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LP_X0       = ADDR_W'(X0_ADDR);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_pending;
    logic                w_wr_acc;

    // An address is live when it maps to a real register that is not the
    // hardwired zero.
    function automatic logic f_addr_live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < LP_NUM_REGS) && !((ZERO_REG != 0) && (a == LP_X0));
    endfunction

    assign w_wr_acc = wr_en && f_addr_live(wr_addr);

    // NOTE: the whole array is reset because every register must read 0
    // after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_acc) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    sc_core_oz_rf_sb #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .CNT_W    (CNT_W)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .i_set_en      (sb_set_en),
        .i_set_addr    (sb_set_addr),
        .i_clr_en      (w_wr_acc),
        .i_clr_addr    (wr_addr),
        .o_pending     (w_pending),
        .o_pending_cnt (pending_cnt)
    );

    // NOTE: every output gets a default before any branch so no latch is
    // inferred when a port's address is invalid.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i] = '0;
            rd_busy[i] = 1'b0;
            if (f_addr_live(rd_addr[i])) begin
                // A forwarded value is the completing result, so the port
                // is not busy even if the register is still marked pending.
                if ((BYPASS != 0) && w_wr_acc && (wr_addr == rd_addr[i])) begin
                    rd_data[i] = wr_data;
                end else begin
                    rd_data[i] = r_regs[rd_addr[i]];
                    rd_busy[i] = w_pending[rd_addr[i]];
                end
            end
        end
    end

endmodule : sc_core_oz_rf_mp

// File: tb/tb_sc_core_oz_rf_mp.sv
// ---------------------------------------------------------------------------
// tb_sc_core_oz_rf_mp
// Bench for sc_core_oz_rf_mp. Two instances share the write/issue inputs:
//   dut_a : defaults (32 regs, 2 ports, bypass on, zero register on)
//   dut_b : 24 regs, 3 ports, bypass off, zero register off
// A behavioural model holds register contents and pending flags as plain
// arrays; pending_cnt is expected to equal the number of set flags.
// ---------------------------------------------------------------------------
module tb_sc_core_oz_rf_mp;
    import sc_core_oz_pkg::*;

    localparam int NREGS_B = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 wr_en;
    t_rf_addr             wr_addr;
    t_rf_data             wr_data;
    logic                 sb_set_en;
    t_rf_addr             sb_set_addr;

    logic [1:0][4:0]      rd_addr_a;
    logic [1:0][31:0]     rd_data_a;
    logic [1:0]           rd_busy_a;
    logic [5:0]           cnt_a;

    logic [2:0][4:0]      rd_addr_b;
    logic [2:0][31:0]     rd_data_b;
    logic [2:0]           rd_busy_b;
    logic [4:0]           cnt_b;

    int n_vec = 0;
    int n_err = 0;

    sc_core_oz_rf_mp dut_a (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr_a),
        .rd_data     (rd_data_a),
        .rd_busy     (rd_busy_a),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .pending_cnt (cnt_a)
    );

    sc_core_oz_rf_mp #(
        .NUM_REGS (NREGS_B),
        .NUM_RD   (3),
        .BYPASS   (0),
        .ZERO_REG (0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr_b),
        .rd_data     (rd_data_b),
        .rd_busy     (rd_busy_b),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .pending_cnt (cnt_b)
    );

    // ---------------- reference model ----------------
    t_rf_data m_regs [2][32];
    bit       m_pend [2][32];

    function automatic int cfg_nregs(int k);
        return (k == 0) ? 32 : NREGS_B;
    endfunction

    function automatic bit cfg_bypass(int k);
        return (k == 0);
    endfunction

    function automatic bit cfg_zero(int k);
        return (k == 0);
    endfunction

    function automatic bit addr_live(int k, t_rf_addr a);
        return (int'(a) < cfg_nregs(k)) && !(cfg_zero(k) && a == 5'd0);
    endfunction

    function automatic bit wr_taken(int k);
        return (wr_en === 1'b1) && addr_live(k, wr_addr);
    endfunction

    function automatic bit forwarded(int k, t_rf_addr a);
        return cfg_bypass(k) && wr_taken(k) && (wr_addr == a);
    endfunction

    function automatic t_rf_data exp_data(int k, t_rf_addr a);
        if (!addr_live(k, a)) return '0;
        if (forwarded(k, a)) return wr_data;
        return m_regs[k][a];
    endfunction

    function automatic logic exp_busy(int k, t_rf_addr a);
        if (!addr_live(k, a) || forwarded(k, a)) return 1'b0;
        return m_pend[k][a];
    endfunction

    function automatic int exp_cnt(int k);
        int s = 0;
        for (int a = 0; a < 32; a++) s += int'(m_pend[k][a]);
        return s;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst === 1'b1) begin
                for (int a = 0; a < 32; a++) begin
                    m_regs[k][a] = '0;
                    m_pend[k][a] = 1'b0;
                end
            end else begin
                if (wr_taken(k)) begin
                    m_regs[k][wr_addr] = wr_data;
                    m_pend[k][wr_addr] = 1'b0;
                end
                if (sb_set_en === 1'b1 && addr_live(k, sb_set_addr))
                    m_pend[k][sb_set_addr] = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst       = 1'b0;
        wr_en     = 1'b0;
        sb_set_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int a = 0; a < 32; a++) begin
            rd_addr_a[0] = 5'(a);
            rd_addr_a[1] = 5'(31 - a);
            rd_addr_b[0] = 5'(a);
            rd_addr_b[1] = 5'(31 - a);
            rd_addr_b[2] = 5'(a);
            @(negedge clk);
            n_vec++;
            if (rd_data_a !== '0 || rd_busy_a !== '0 || cnt_a !== 6'd0) begin
                $display("FAIL reset_a addr=%0d data=%h busy=%b cnt=%0d expected all 0",
                         a, rd_data_a, rd_busy_a, cnt_a);
                n_err++;
            end
            n_vec++;
            if (rd_data_b !== '0 || rd_busy_b !== '0 || cnt_b !== 5'd0) begin
                $display("FAIL reset_b addr=%0d data=%h busy=%b cnt=%0d expected all 0",
                         a, rd_data_b, rd_busy_b, cnt_b);
                n_err++;
            end
        end
        next_cycle();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        next_cycle();
        idle();
        rd_addr_a[0] = 5'd5; rd_addr_a[1] = 5'd0;
        rd_addr_b[0] = 5'd5; rd_addr_b[1] = 5'd0;
        @(negedge clk);
        n_vec++;
        if (rd_data_a[0] !== 32'hDEADBEEF) begin
            $display("FAIL wr_x5_a got=%h exp=%h", rd_data_a[0], 32'hDEADBEEF); n_err++;
        end
        n_vec++;
        if (rd_data_a[1] !== 32'h0) begin
            $display("FAIL rd_x0_a got=%h exp=0", rd_data_a[1]); n_err++;
        end
        n_vec++;
        if (rd_data_b[0] !== 32'hDEADBEEF) begin
            $display("FAIL wr_x5_b got=%h exp=%h", rd_data_b[0], 32'hDEADBEEF); n_err++;
        end
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        next_cycle();
        idle();
        rd_addr_a[0] = 5'd0; rd_addr_b[0] = 5'd0;
        @(negedge clk);
        n_vec++;
        if (rd_data_a[0] !== 32'h0) begin
            $display("FAIL wr_x0_ignored_a got=%h exp=0", rd_data_a[0]); n_err++;
        end
        n_vec++;
        if (rd_data_b[0] !== 32'h1234) begin
            $display("FAIL wr_x0_plain_b got=%h exp=%h", rd_data_b[0], 32'h1234); n_err++;
        end
        next_cycle();
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rd_addr_a[1] = 5'd7; rd_addr_b[1] = 5'd7;
        @(negedge clk);
        n_vec++;
        if (rd_data_a[1] !== 32'hA5A5A5A5) begin
            $display("FAIL bypass_a got=%h exp=%h", rd_data_a[1], 32'hA5A5A5A5); n_err++;
        end
        n_vec++;
        if (rd_data_b[1] !== 32'h0) begin
            $display("FAIL nobypass_old_b got=%h exp=0", rd_data_b[1]); n_err++;
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++;
        if (rd_data_b[1] !== 32'hA5A5A5A5) begin
            $display("FAIL nobypass_new_b got=%h exp=%h", rd_data_b[1], 32'hA5A5A5A5); n_err++;
        end
        next_cycle();
    endtask

    task automatic test_scoreboard();
        sb_set_en = 1'b1; sb_set_addr = 5'd3;
        next_cycle();
        idle();
        rd_addr_a[0] = 5'd3; rd_addr_b[0] = 5'd3;
        @(negedge clk);
        n_vec++;
        if (rd_busy_a[0] !== 1'b1 || cnt_a !== 6'd1) begin
            $display("FAIL sb_set_x3_a busy=%b cnt=%0d exp busy=1 cnt=1", rd_busy_a[0], cnt_a); n_err++;
        end
        n_vec++;
        if (rd_busy_b[0] !== 1'b1 || cnt_b !== 5'd1) begin
            $display("FAIL sb_set_x3_b busy=%b cnt=%0d exp busy=1 cnt=1", rd_busy_b[0], cnt_b); n_err++;
        end
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
        @(negedge clk);
        n_vec++;
        if (rd_busy_a[0] !== 1'b0 || rd_data_a[0] !== 32'h11) begin
            $display("FAIL sb_fwd_x3_a busy=%b data=%h exp busy=0 data=11", rd_busy_a[0], rd_data_a[0]); n_err++;
        end
        n_vec++;
        if (rd_busy_b[0] !== 1'b1 || rd_data_b[0] !== 32'h0) begin
            $display("FAIL sb_nofwd_x3_b busy=%b data=%h exp busy=1 data=0", rd_busy_b[0], rd_data_b[0]); n_err++;
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++;
        if (rd_busy_a[0] !== 1'b0 || cnt_a !== 6'd0 || rd_busy_b[0] !== 1'b0 || cnt_b !== 5'd0) begin
            $display("FAIL sb_clr_x3 busy_a=%b cnt_a=%0d busy_b=%b cnt_b=%0d exp all 0",
                     rd_busy_a[0], cnt_a, rd_busy_b[0], cnt_b); n_err++;
        end
        next_cycle();
    endtask

    task automatic test_set_wins();
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h22;
        next_cycle();
        idle();
        rd_addr_a[0] = 5'd9; rd_addr_b[0] = 5'd9;
        @(negedge clk);
        n_vec++;
        if (rd_busy_a[0] !== 1'b1 || cnt_a !== 6'd1 || rd_data_a[0] !== 32'h22) begin
            $display("FAIL set_wins_a busy=%b cnt=%0d data=%h exp busy=1 cnt=1 data=22",
                     rd_busy_a[0], cnt_a, rd_data_a[0]); n_err++;
        end
        n_vec++;
        if (rd_busy_b[0] !== 1'b1 || cnt_b !== 5'd1 || rd_data_b[0] !== 32'h22) begin
            $display("FAIL set_wins_b busy=%b cnt=%0d data=%h exp busy=1 cnt=1 data=22",
                     rd_busy_b[0], cnt_b, rd_data_b[0]); n_err++;
        end
        next_cycle();
    endtask

    task automatic test_reset_priority();
        // x9 is still pending from the previous scenario.
        sb_set_en = 1'b1;
        sb_set_addr = 5'd1; next_cycle();
        sb_set_addr = 5'd2; next_cycle();
        sb_set_addr = 5'd4; next_cycle();
        idle();
        @(negedge clk);
        n_vec++;
        if (cnt_a !== 6'd4 || cnt_b !== 5'd4) begin
            $display("FAIL cnt_before_rst a=%0d b=%0d exp 4", cnt_a, cnt_b); n_err++;
        end
        next_cycle();
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFF;
        sb_set_en = 1'b1; sb_set_addr = 5'd6;
        next_cycle();
        idle();
        rd_addr_a[0] = 5'd1; rd_addr_a[1] = 5'd9;
        rd_addr_b[0] = 5'd1; rd_addr_b[1] = 5'd9; rd_addr_b[2] = 5'd5;
        @(negedge clk);
        n_vec++;
        if (cnt_a !== 6'd0 || cnt_b !== 5'd0 || rd_busy_a !== 2'b00 || rd_busy_b !== 3'b000) begin
            $display("FAIL rst_clears_sb cnt_a=%0d cnt_b=%0d busy_a=%b busy_b=%b exp all 0",
                     cnt_a, cnt_b, rd_busy_a, rd_busy_b); n_err++;
        end
        n_vec++;
        if (rd_data_a[0] !== 32'h0 || rd_data_b[0] !== 32'h0 || rd_data_b[2] !== 32'h0) begin
            $display("FAIL rst_over_write x1_a=%h x1_b=%h x5_b=%h exp 0",
                     rd_data_a[0], rd_data_b[0], rd_data_b[2]); n_err++;
        end
        next_cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst         = ($urandom_range(0, 79) == 0);
            wr_en       = $urandom_range(0, 1) == 1;
            wr_addr     = $urandom_range(0, 1) ? t_rf_addr'($urandom_range(0, 7))
                                               : t_rf_addr'($urandom_range(0, 31));
            wr_data     = $urandom;
            sb_set_en   = $urandom_range(0, 2) == 0;
            sb_set_addr = $urandom_range(0, 1) ? t_rf_addr'($urandom_range(0, 7))
                                               : t_rf_addr'($urandom_range(0, 31));
            for (int p = 0; p < 2; p++)
                rd_addr_a[p] = ($urandom_range(0, 3) == 0) ? wr_addr
                                                           : t_rf_addr'($urandom_range(0, 31));
            for (int p = 0; p < 3; p++)
                rd_addr_b[p] = ($urandom_range(0, 3) == 0) ? wr_addr
                                                           : t_rf_addr'($urandom_range(0, 31));
            @(negedge clk);
            if (!rst) begin
                for (int p = 0; p < 2; p++) begin
                    n_vec++;
                    if (rd_data_a[p] !== exp_data(0, rd_addr_a[p]) ||
                        rd_busy_a[p] !== exp_busy(0, rd_addr_a[p])) begin
                        $display("FAIL rand_a cyc=%0d port=%0d addr=%0d data=%h busy=%b exp data=%h busy=%b",
                                 c, p, rd_addr_a[p], rd_data_a[p], rd_busy_a[p],
                                 exp_data(0, rd_addr_a[p]), exp_busy(0, rd_addr_a[p]));
                        n_err++;
                    end
                end
                for (int p = 0; p < 3; p++) begin
                    n_vec++;
                    if (rd_data_b[p] !== exp_data(1, rd_addr_b[p]) ||
                        rd_busy_b[p] !== exp_busy(1, rd_addr_b[p])) begin
                        $display("FAIL rand_b cyc=%0d port=%0d addr=%0d data=%h busy=%b exp data=%h busy=%b",
                                 c, p, rd_addr_b[p], rd_data_b[p], rd_busy_b[p],
                                 exp_data(1, rd_addr_b[p]), exp_busy(1, rd_addr_b[p]));
                        n_err++;
                    end
                end
            end
            n_vec++;
            if (cnt_a !== 6'(exp_cnt(0)) || cnt_b !== 5'(exp_cnt(1))) begin
                $display("FAIL rand_cnt cyc=%0d cnt_a=%0d cnt_b=%0d exp a=%0d b=%0d",
                         c, cnt_a, cnt_b, exp_cnt(0), exp_cnt(1));
                n_err++;
            end
            next_cycle();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        repeat (2) @(posedge clk);
        #1;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_set_wins();
        test_reset_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sc_core_oz_rf_mp
